// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   - state encoding for the drain FSM (3-bit, legacy-compatible constants)
//   - default bit period in clock cycles
//   - even-parity helper
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state to the frame).
package uart_pkg;

  localparam int STATE_W              = 3;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_START  = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_PARITY = 3'd4;
  localparam state_t ST_STOP   = 3'd5;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high during the last count.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous active-high reset (count -> 0)
//   clear  in  synchronous restart of the count at 0 on the next edge
//   tick   out high while count == CLKS_PER_BIT-1
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [15:0] count;

  assign tick = (count == 16'(CLKS_PER_BIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (clear || tick) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains an upstream 8-bit FIFO.
// Whenever the FIFO is non-empty and the transmitter is idle it pops one
// byte and sends it as an 8N1 frame (8E1 when UART_TX_PARITY_EN is defined).
//
// Upstream handshake: read is a one-cycle pop strobe, raised only in IDLE
// while empty is low; the FIFO presents the popped byte on datain in the
// following cycle (FETCH), which is the only cycle datain is sampled.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous active-high reset (aborts any frame)
//   empty      in   upstream FIFO empty flag
//   datain     in   upstream FIFO read data (registered in the FIFO)
//   read       out  pop request, combinational from state/empty
//   tx         out  registered serial line, idle high
//   busy       out  high in every state except IDLE
//   dbg_state  out  current FSM state (uart_pkg encoding)
// Optional feature macro: UART_TX_PARITY_EN.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               empty,
  input  logic [7:0]         datain,
  output logic               read,
  output logic               tx,
  output logic               busy,
  output logic [STATE_W-1:0] dbg_state
);

  state_t     state, state_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic [7:0] shreg, shreg_next;
  logic       tx_next;
  logic       tick;
  logic       timer_clear;
  logic       parity_q;

  // The timer restarts on every state change so each state spans exactly
  // CLKS_PER_BIT cycles; it is also held at 0 while idle.
  assign timer_clear = (state_next != state) || (state == ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(timer_clear),
    .tick (tick)
  );

  assign read      = (state == ST_IDLE) && !empty && !reset;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    case (state)
      ST_IDLE: begin
        if (!empty) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        shreg_next = datain;
        state_next = ST_START;
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shreg_next   = {1'b0, shreg[7:1]};
          // 3-bit index wraps 7 -> 0 as the last data bit completes.
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // tx is computed from the next state so the registered line changes on
  // the same edge as the state, with no extra cycle of lag.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shreg_next[0];
      ST_PARITY: tx_next = parity_q;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      tx      <= tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (state == ST_FETCH) begin
      parity_q <= even_parity(datain);
    end
  end
`else
  assign parity_q = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed testbench for uart_tx_drain with CLKS_PER_BIT = 4.
// A small FIFO model feeds the DUT; frames are checked cycle by cycle
// against hand-written bytes and parity bits.
module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic               clock;
  logic               reset;
  logic               empty;
  logic [7:0]         datain;
  logic               read;
  logic               tx;
  logic               busy;
  logic [STATE_W-1:0] dbg_state;

  int vec_cnt;
  int err_cnt;
  int cyc;

  // FIFO model
  logic [7:0] fifo_mem [0:15];
  int         wr_ptr;
  int         rd_ptr;
  int         read_cnt;
  logic       hold;

  assign empty = (wr_ptr == rd_ptr) || hold;

  uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .empty    (empty),
    .datain   (datain),
    .read     (read),
    .tx       (tx),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (read) begin
      datain   <= fifo_mem[rd_ptr[3:0]];
      rd_ptr   <= rd_ptr + 1;
      read_cnt <= read_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, got running need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Waits up to 40 cycles for a start bit; leaves simulation at the negedge
  // of the first start-bit cycle.
  task automatic wait_start(output logic found);
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clock);
      if (tx === 1'b0) found = 1'b1;
    end
    check("start_seen", 16'(found), 16'd1);
  endtask

  // Checks a whole frame for byte d (par = hand-computed even parity),
  // then the return to idle.
  task automatic check_frame(input logic [7:0] d, input logic par, output int start_cyc);
    logic found;
    logic exp;
    start_cyc = -1;
    wait_start(found);
    if (found) begin
      start_cyc = cyc;
      for (int i = 0; i < NBITS; i++) begin
        if (i == 0)                     exp = 1'b0;
        else if (i <= 8)                exp = d[i-1];
        else if (i == 9 && NBITS == 11) exp = par;
        else                            exp = 1'b1;
        for (int k = 0; k < CPB; k++) begin
          if (!(i == 0 && k == 0)) @(negedge clock);
          check($sformatf("frame_%0h_bit%0d", d, i), 16'(tx), 16'(exp));
          if (k == 0) check($sformatf("busy_%0h_bit%0d", d, i), 16'(busy), 16'd1);
        end
      end
      @(negedge clock);
      check($sformatf("idle_tx_%0h", d), 16'(tx), 16'd1);
      check($sformatf("idle_busy_%0h", d), 16'(busy), 16'd0);
    end
  endtask

  initial begin
    int   s1, s2, rc0;
    logic found;
    vec_cnt = 0; err_cnt = 0; cyc = 0;
    wr_ptr = 0; rd_ptr = 0; read_cnt = 0;
    hold = 1'b0;
    datain = 8'h00;
    reset = 1'b1;

    // Reset with data waiting: nothing must move.
    push_byte(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("rst_tx", 16'(tx), 16'd1);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_read", 16'(read), 16'd0);
      check("rst_state", 16'(dbg_state), 16'(ST_IDLE));
    end
    reset = 1'b0;
    #1;
    check("rel_read", 16'(read), 16'd1);

    // Single byte 0xA5 (even parity 0).
    check_frame(8'hA5, 1'b0, s1);
    check("a5_reads", 16'(read_cnt), 16'd1);

    // Back-to-back 0x00 then 0xFF.
    @(negedge clock);
    rc0 = read_cnt;
    hold = 1'b1;
    push_byte(8'h00);
    push_byte(8'hFF);
    hold = 1'b0;
    check_frame(8'h00, 1'b0, s1);
    check_frame(8'hFF, 1'b0, s2);
    check("b2b_spacing", 16'(s2 - s1), 16'(NBITS * CPB + 2));
    repeat (5) @(negedge clock);
    check("b2b_reads", 16'(read_cnt - rc0), 16'd2);

    // Empty idle for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check("idle_read", 16'(read), 16'd0);
      check("idle_tx", 16'(tx), 16'd1);
      check("idle_busy", 16'(busy), 16'd0);
    end

    // Reset during data bit 3 of 0x3C; 0x5A follows afterwards.
    rc0 = read_cnt;
    hold = 1'b1;
    push_byte(8'h3C);
    push_byte(8'h5A);
    hold = 1'b0;
    wait_start(found);
    if (found) begin
      repeat (4 * CPB + 1) @(negedge clock);
      check("mid_bit3", 16'(tx), 16'd1);
      check("mid_busy", 16'(busy), 16'd1);
      check("mid_state", 16'(dbg_state), 16'(ST_DATA));
      reset = 1'b1;
      #1;
      check("abort_tx", 16'(tx), 16'd1);
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_state", 16'(dbg_state), 16'(ST_IDLE));
      check("abort_read", 16'(read), 16'd0);
      @(negedge clock);
      check("abort_hold_tx", 16'(tx), 16'd1);
      reset = 1'b0;
      #1;
      check("rel2_read", 16'(read), 16'd1);
      check_frame(8'h5A, 1'b0, s1);
      check("abort_reads", 16'(read_cnt - rc0), 16'd2);
    end

`ifdef UART_TX_PARITY_EN
    // 0x01 has odd weight -> parity bit 1.
    @(negedge clock);
    push_byte(8'h01);
    check_frame(8'h01, 1'b1, s1);
`endif

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal 2..65535).
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port empty  input  1  upstream 8-bit FIFO empty flag.
REQ-005 SHALL have port datain  input  8  upstream FIFO read data, registered, valid the cycle after read is high.
REQ-006 SHALL have port read  output  1  one-cycle pop request to the upstream FIFO.
REQ-007 SHALL have port tx  output  1  serial line, idle high, 8N1 frame (8E1 with parity).
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-010 SHALL assert read combinationally only when state==IDLE and empty==0; read SHALL never be high for two consecutive cycles.
REQ-011 SHALL move IDLE->FETCH on the cycle read is high; stay in IDLE while empty==1.
REQ-012 SHALL in FETCH capture datain into an 8-bit shift register and move to START on the next edge (FETCH lasts exactly 1 cycle).
REQ-013 SHALL hold tx=0 for CLKS_PER_BIT cycles in START, then enter DATA.
REQ-014 SHALL send 8 data bits LSB first in DATA, each held CLKS_PER_BIT cycles, tracked by a 3-bit index that wraps 7->0 on exit.
REQ-015 SHALL after bit 7 go to PARITY when enabled (REQ-024), else to STOP.
REQ-016 SHALL hold tx=1 for CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-017 SHALL drive tx=1 in IDLE and FETCH.
REQ-018 SHALL use a 16-bit bit-timer counting 0..CLKS_PER_BIT-1, cleared on every state change; state advances when timer==CLKS_PER_BIT-1.
REQ-019 SHALL register tx (no combinational glitches on the line).
REQ-020 SHALL ignore datain in every state except FETCH; changes to empty during a frame SHALL have no effect until IDLE.
REQ-021 SHALL yield a back-to-back frame spacing of (10 or 11)*CLKS_PER_BIT + 2 cycles when empty stays low (IDLE and FETCH cycles between frames).

Reset
REQ-022 SHALL on reset asynchronously force state=IDLE, tx=1, busy=0, timer=0, bit index=0, shift register=0; read SHALL be 0 while reset is high.
REQ-023 SHALL on reset mid-frame abort the frame with tx=1 immediately; the popped byte is lost, no re-read.

Configuration
REQ-024 SHALL compile the PARITY state in when macro UART_TX_PARITY_EN is defined: one even-parity bit (XOR of the 8 data bits) held CLKS_PER_BIT cycles between DATA and STOP; without the macro PARITY is unreachable/absent and the frame is 10 bits.

Structure
REQ-025 SHALL take the FSM state enum, state width and default CLKS_PER_BIT from shared package uart_pkg.
REQ-026 SHALL place the bit-timer in sub-module uart_bit_timer (inputs clock, reset, clear; output tick).

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL check reset: reset=1 with empty=0 -> tx=1, busy=0, read=0 throughout; after release read=1 on first cycle.
REQ-028 SHALL check single byte: FIFO holds 0xA5, empty falls -> read one cycle, tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles), then idle high.
REQ-029 SHALL check back-to-back: 0x00 then 0xFF queued -> second start bit begins exactly 42 cycles after first start bit; exactly two read pulses.
REQ-030 SHALL check empty idle: empty=1 for 100 cycles -> read=0, tx=1, busy=0 every cycle.
REQ-031 SHALL check reset mid-frame: reset pulsed during data bit 3 of 0x3C -> tx=1 same cycle, state IDLE, next frame after release is correct for the next FIFO byte.
REQ-032 SHALL check parity (UART_TX_PARITY_EN): 0xA5 -> parity bit 0; 0x01 -> parity bit 1; frame 44 cycles.
